// File: rtl/mem_lab_defs_pkg.sv
// Definitions shared by the memory-lab blocks: default widths, SRAM strobe
// polarities and the loader state encoding.
package mem_lab_defs;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  // SRAM control pins are active-low.
  localparam logic CS_ON  = 1'b0;
  localparam logic CS_OFF = 1'b1;
  localparam logic WE_WR  = 1'b0;
  localparam logic WE_OFF = 1'b1;
  localparam logic OE_RD  = 1'b0;
  localparam logic OE_OFF = 1'b1;

  typedef enum logic [3:0] {
    LD_IDLE   = 4'd0,
    LD_ACCEPT = 4'd1,
    LD_WRITE  = 4'd2,
    LD_VRD    = 4'd3,
    LD_VWAIT  = 4'd4,
    LD_CMP    = 4'd5,
    LD_START  = 4'd6,
    LD_DONE   = 4'd7,
    LD_ERROR  = 4'd8
  } ld_state_e;

  function automatic logic ld_is_busy(input ld_state_e s);
    return (s == LD_ACCEPT) || (s == LD_WRITE) || (s == LD_VRD) ||
           (s == LD_VWAIT)  || (s == LD_CMP)   || (s == LD_START);
  endfunction

endpackage

// File: rtl/sram_loader_sum8_acc.sv
// Clearable modulo-2**W running sum, used for both the write and readback checksums.
module sum8_acc
  import mem_lab_defs::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] sum_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sum_q <= '0;
    else if (clr_i) sum_q <= '0;
    else if (en_i)  sum_q <= sum_q + data_i;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/sram_loader.sv
// Fills a synchronous SRAM from a valid/ready byte stream, optionally verifies the
// image with a byte checksum, then issues a one-cycle start request to the controller.
module sram_loader
  import mem_lab_defs::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LOAD_COUNT = 8,
  parameter int BASE_ADDR  = 0,
  parameter int VERIFY     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_go,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              start_pulse,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(LOAD_COUNT - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              cs_n_q, we_n_q, oe_n_q;
  logic              in_ready_q, start_q, busy_q, done_q, error_q;

  logic              sum_clr, wsum_en, rsum_en, take_byte;
  logic [DATA_W-1:0] wsum, rsum;

  sum8_acc #(.W(DATA_W)) u_wsum (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (sum_clr),
    .en_i   (wsum_en),
    .data_i (in_data),
    .sum_o  (wsum)
  );

  sum8_acc #(.W(DATA_W)) u_rsum (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (sum_clr),
    .en_i   (rsum_en),
    .data_i (sram_dout),
    .sum_o  (rsum)
  );

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_clr   = 1'b0;
    wsum_en   = 1'b0;
    rsum_en   = 1'b0;
    take_byte = 1'b0;
    unique case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (load_go) begin
          state_d = LD_ACCEPT;
          cnt_d   = '0;
          sum_clr = 1'b1;
        end
      end
      LD_ACCEPT: begin
        if (in_valid && in_ready_q) begin
          take_byte = 1'b1;
          wsum_en   = 1'b1;
          state_d   = LD_WRITE;
        end
      end
      LD_WRITE: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = (VERIFY != 0) ? LD_VRD : LD_START;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = LD_ACCEPT;
        end
      end
      LD_VRD: state_d = LD_VWAIT;
      LD_VWAIT: begin
        rsum_en = 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = LD_CMP;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = LD_VRD;
        end
      end
      // rsum already includes the final VWAIT byte here.
      LD_CMP:   state_d = (rsum == wsum) ? LD_START : LD_ERROR;
      LD_START: state_d = LD_DONE;
      default:  state_d = LD_IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state, so they line up with the state they describe.
  always_comb begin
    addr_d = addr_q;
    if (state_d == LD_WRITE || state_d == LD_VRD) addr_d = BASE + cnt_d;
    din_d = take_byte ? in_data : din_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LD_IDLE;
      cnt_q      <= '0;
      addr_q     <= BASE;
      din_q      <= '0;
      cs_n_q     <= CS_OFF;
      we_n_q     <= WE_OFF;
      oe_n_q     <= OE_OFF;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      cs_n_q     <= (state_d == LD_WRITE || state_d == LD_VRD) ? CS_ON : CS_OFF;
      we_n_q     <= (state_d == LD_WRITE) ? WE_WR : WE_OFF;
      oe_n_q     <= (state_d == LD_VRD)   ? OE_RD : OE_OFF;
      in_ready_q <= (state_d == LD_ACCEPT);
      start_q    <= (state_d == LD_START);
      busy_q     <= ld_is_busy(state_d);
      done_q     <= (state_d == LD_DONE);
      error_q    <= (state_d == LD_ERROR);
    end
  end

  assign in_ready    = in_ready_q;
  assign sram_cs_n   = cs_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_addr   = addr_q;
  assign sram_din    = din_q;
  assign start_pulse = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_sram_loader.sv
// Directed bench for sram_loader: default, wrapped-window and no-verify instances,
// each with a small behavioural SRAM.
module tb_sram_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (BASE 0, 8 bytes, verify on)
  logic       a_go, a_iv, a_ir, a_cs, a_we, a_oe, a_sp, a_busy, a_done, a_err, a_corrupt;
  logic [7:0] a_id, a_din, a_dout;
  logic [4:0] a_addr;
  logic [7:0] a_mem [32];

  sram_loader dut_a (
    .clk(clk), .reset(reset), .load_go(a_go), .in_valid(a_iv), .in_data(a_id),
    .in_ready(a_ir), .sram_cs_n(a_cs), .sram_we_n(a_we), .sram_oe_n(a_oe),
    .sram_addr(a_addr), .sram_din(a_din), .sram_dout(a_dout),
    .start_pulse(a_sp), .busy(a_busy), .done(a_done), .error(a_err)
  );

  always @(posedge clk) begin
    if (!a_cs && !a_we) a_mem[a_addr] <= a_din;
    if (!a_cs && !a_oe) a_dout <= a_mem[a_addr] + ((a_corrupt && a_addr == 5'd3) ? 8'd1 : 8'd0);
  end

  // Instance B: window starting at 30 wraps past the top of the address space
  logic       b_go, b_iv, b_ir, b_cs, b_we, b_oe, b_sp, b_busy, b_done, b_err;
  logic [7:0] b_id, b_din, b_dout;
  logic [4:0] b_addr;
  logic [7:0] b_mem [32];

  sram_loader #(.LOAD_COUNT(4), .BASE_ADDR(30)) dut_b (
    .clk(clk), .reset(reset), .load_go(b_go), .in_valid(b_iv), .in_data(b_id),
    .in_ready(b_ir), .sram_cs_n(b_cs), .sram_we_n(b_we), .sram_oe_n(b_oe),
    .sram_addr(b_addr), .sram_din(b_din), .sram_dout(b_dout),
    .start_pulse(b_sp), .busy(b_busy), .done(b_done), .error(b_err)
  );

  always @(posedge clk) begin
    if (!b_cs && !b_we) b_mem[b_addr] <= b_din;
    if (!b_cs && !b_oe) b_dout <= b_mem[b_addr];
  end

  // Instance C: no readback
  logic       c_go, c_iv, c_ir, c_cs, c_we, c_oe, c_sp, c_busy, c_done, c_err;
  logic [7:0] c_id, c_din, c_dout;
  logic [4:0] c_addr;
  logic [7:0] c_mem [32];

  sram_loader #(.VERIFY(0)) dut_c (
    .clk(clk), .reset(reset), .load_go(c_go), .in_valid(c_iv), .in_data(c_id),
    .in_ready(c_ir), .sram_cs_n(c_cs), .sram_we_n(c_we), .sram_oe_n(c_oe),
    .sram_addr(c_addr), .sram_din(c_din), .sram_dout(c_dout),
    .start_pulse(c_sp), .busy(c_busy), .done(c_done), .error(c_err)
  );

  always @(posedge clk) begin
    if (!c_cs && !c_we) c_mem[c_addr] <= c_din;
    if (!c_cs && !c_oe) c_dout <= c_mem[c_addr];
  end

  logic overlap = 1'b0;
  always @(posedge clk)
    if ((!a_we && !a_oe) || (!b_we && !b_oe) || (!c_we && !c_oe)) overlap <= 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] img_a();
    logic [63:0] v = '0;
    for (int i = 7; i >= 0; i--) v = {v[55:0], a_mem[i]};
    return v;
  endfunction

  // Load first..first+7 into A with in_valid held; a decoy byte sits on in_data in the load_go cycle.
  task automatic run_a(input logic [7:0] first,
                       output logic [63:0] ir_v, output logic [63:0] wr_v,
                       output logic [63:0] rd_v, output logic [63:0] sp_v,
                       output logic [63:0] bz_v, output logic [63:0] er_v);
    ir_v = '0; wr_v = '0; rd_v = '0; sp_v = '0; bz_v = '0; er_v = '0;
    a_go = 1'b1; a_iv = 1'b1; a_id = 8'hEE;
    for (int c = 1; c <= 40; c++) begin
      tick();
      a_go = 1'b0;
      if (c % 2 == 1) a_id = first + 8'((c - 1) / 2);
      ir_v[c] = a_ir;  wr_v[c] = ~a_we; rd_v[c] = ~a_oe;
      sp_v[c] = a_sp;  bz_v[c] = a_busy; er_v[c] = a_err;
    end
    a_iv = 1'b0;
  endtask

  logic [63:0] ir_v, wr_v, rd_v, sp_v, bz_v, er_v;
  logic [7:0]  t2_bytes [8];
  logic [31:0] wa, ra;
  int          idx, wcnt, sp_at, spc;
  logic        xfer, flag_a, flag_b;

  initial begin
    reset = 1'b1;
    a_go = 0; a_iv = 0; a_id = 0; a_corrupt = 0;
    b_go = 0; b_iv = 0; b_id = 0;
    c_go = 0; c_iv = 0; c_id = 0;
    t2_bytes = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h81, 8'h7E};
    tick();

    check("rst_strobes", {a_cs, a_we, a_oe}, 3'b111);
    check("rst_addr_a", a_addr, 5'd0);
    check("rst_addr_b", b_addr, 5'd30);
    check("rst_din", a_din, 8'h00);
    check("rst_flags", {a_ir, a_sp, a_busy, a_done, a_err}, 5'b00000);
    reset = 1'b0;
    tick();

    // T1: bytes 1..8, in_valid held high
    run_a(8'h01, ir_v, wr_v, rd_v, sp_v, bz_v, er_v);
    check("t1_in_ready", ir_v, 64'hAAAA);
    check("t1_writes", wr_v, 64'h15554);
    check("t1_reads", rd_v, 64'hAAAA_0000);
    check("t1_start", sp_v, 64'h4_0000_0000);
    check("t1_busy", bz_v, 64'h7_FFFF_FFFE);
    check("t1_error", er_v, 64'h0);
    check("t1_done", a_done, 1'b1);
    check("t1_image", img_a(), 64'h0807060504030201);

    // T2: gappy producer
    a_go = 1'b1; a_iv = 1'b0;
    tick();
    a_go = 1'b0;
    idx = 0; wcnt = 0; flag_a = 1'b1;
    for (int c = 0; c < 200 && !a_done && !a_err; c++) begin
      a_iv = ($urandom_range(0, 1) == 1) && (idx < 8);
      a_id = (idx < 8) ? t2_bytes[idx] : 8'h00;
      xfer = a_iv && a_ir;
      flag_a &= a_busy;
      tick();
      if (xfer) idx++;
      if (!a_we) wcnt++;
    end
    a_iv = 1'b0;
    check("t2_bytes_taken", idx, 8);
    check("t2_write_count", wcnt, 8);
    check("t2_busy_held", flag_a, 1'b1);
    check("t2_done", {a_done, a_err}, 2'b10);
    check("t2_image", img_a(), 64'h7E81A55AFF00C33C);

    // T3: readback of address 3 corrupted
    a_corrupt = 1'b1;
    run_a(8'h01, ir_v, wr_v, rd_v, sp_v, bz_v, er_v);
    a_corrupt = 1'b0;
    check("t3_no_start", sp_v, 64'h0);
    check("t3_error_from_34", er_v, 64'h1FC_0000_0000);
    check("t3_done", a_done, 1'b0);

    // T4: reset on the fifth write cycle
    a_go = 1'b1; a_iv = 1'b1; a_id = 8'hEE;
    for (int c = 1; c <= 10; c++) begin
      tick();
      a_go = 1'b0;
      if (c % 2 == 1) a_id = 8'h01 + 8'((c - 1) / 2);
    end
    check("t4_in_write", {a_cs, a_we, a_oe}, 3'b001);
    reset = 1'b1;
    #1;
    check("t4_async_strobes", {a_cs, a_we, a_oe}, 3'b111);
    check("t4_async_busy", a_busy, 1'b0);
    a_iv = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    flag_a = 1'b0; flag_b = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      flag_a |= a_sp;
      flag_b |= a_busy | a_done | a_err;
    end
    check("t4_no_start", flag_a, 1'b0);
    check("t4_idle", flag_b, 1'b0);
    run_a(8'h10, ir_v, wr_v, rd_v, sp_v, bz_v, er_v);
    check("t4_reload_start", sp_v, 64'h4_0000_0000);
    check("t4_reload_done", {a_done, a_err}, 2'b10);
    check("t4_reload_image", img_a(), 64'h1716151413121110);

    // T5: wrapped window, bytes A0..A3
    b_go = 1'b1; b_iv = 1'b1; b_id = 8'hEE;
    wa = '0; ra = '0; sp_at = 0; spc = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      b_go = 1'b0;
      if (c % 2 == 1 && c <= 7) b_id = 8'hA0 + 8'((c - 1) / 2);
      if (!b_we) wa = {wa[23:0], 3'b000, b_addr};
      if (!b_oe) ra = {ra[23:0], 3'b000, b_addr};
      if (b_sp) begin sp_at = c; spc++; end
    end
    b_iv = 1'b0;
    check("t5_write_addrs", wa, 32'h1E1F0001);
    check("t5_read_addrs", ra, 32'h1E1F0001);
    check("t5_start_cycle", sp_at, 18);
    check("t5_start_count", spc, 1);
    check("t5_done", {b_done, b_err}, 2'b10);
    check("t5_image", {b_mem[30], b_mem[31], b_mem[0], b_mem[1]}, 32'hA0A1A2A3);

    // T6: no verify, load_go pulsed mid-load
    c_go = 1'b1; c_iv = 1'b1; c_id = 8'hEE;
    sp_v = '0; rd_v = '0; bz_v = '0; wcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      c_go = (c == 3);
      if (c % 2 == 1 && c <= 15) c_id = 8'h01 + 8'((c - 1) / 2);
      sp_v[c] = c_sp; rd_v[c] = ~c_oe; bz_v[c] = c_busy;
      if (!c_we) wcnt++;
    end
    c_iv = 1'b0;
    check("t6_start", sp_v, 64'h2_0000);
    check("t6_no_reads", rd_v, 64'h0);
    check("t6_busy", bz_v, 64'h3_FFFE);
    check("t6_write_count", wcnt, 8);
    check("t6_done", {c_done, c_err}, 2'b10);
    check("t6_image", {c_mem[7], c_mem[6], c_mem[5], c_mem[4], c_mem[3], c_mem[2], c_mem[1], c_mem[0]},
          64'h0807060504030201);

    check("no_rw_overlap", overlap, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
